// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - decode-stage issue controller with int/float write scoreboard
// Blocks issue on RAW/WAW hazards or a full outstanding-write budget, and runs the drain FSM.
module decode_issue_ctrl #(
   parameter int MAX_OUT = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [4:0]       in_src1_no,
   input  logic             in_src1_f,
   input  logic             in_src1_use,
   input  logic [4:0]       in_src2_no,
   input  logic             in_src2_f,
   input  logic             in_src2_use,
   input  logic [4:0]       in_dst_no,
   input  logic             in_dst_f,
   input  logic             in_dst_wr,
   input  logic             flush,
   input  logic             wb_valid,
   input  logic [4:0]       wb_no,
   input  logic             wb_f,
   input  logic             drain_req,
   output logic             issue_en,
   output logic             stall,
   output logic             drained,
   output logic [31:0]      pend_int,
   output logic [31:0]      pend_fp,
   output logic [3:0]       out_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             wb_err
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, IDLE = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_pend_int;
   logic [31:0]      r_pend_fp;
   logic [31:0]      w_pend_int_nxt;
   logic [31:0]      w_pend_fp_nxt;
   logic [3:0]       r_out_cnt;
   logic [3:0]       w_out_cnt_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_wb_err;
   logic             r_drained;

   logic w_raw1, w_raw2, w_waw, w_full, w_run;
   logic w_issue_wr, w_wb_int0, w_wb_hit, w_wb_dec;

   // Integer register 0 is hardwired and therefore never pending.
   function automatic logic f_pend(input logic [31:0] pi, input logic [31:0] pf,
                                   input logic [4:0] no, input logic is_f);
      if (is_f) return pf[no];
      return (no != 5'd0) && pi[no];
   endfunction

   assign w_raw1 = in_src1_use & f_pend(r_pend_int, r_pend_fp, in_src1_no, in_src1_f);
   assign w_raw2 = in_src2_use & f_pend(r_pend_int, r_pend_fp, in_src2_no, in_src2_f);
   assign w_waw  = in_dst_wr   & f_pend(r_pend_int, r_pend_fp, in_dst_no, in_dst_f);
   assign w_full = in_dst_wr   & (r_out_cnt == 4'(MAX_OUT));
   assign w_run  = (r_state == RUN) & ~drain_req;

   assign issue_en   = in_valid & ~flush & w_run & ~w_raw1 & ~w_raw2 & ~w_waw & ~w_full;
   assign stall      = in_valid & ~issue_en & ~flush;
   assign w_issue_wr = issue_en & in_dst_wr;

   assign w_wb_int0 = wb_valid & ~wb_f & (wb_no == 5'd0);
   assign w_wb_hit  = wb_valid & f_pend(r_pend_int, r_pend_fp, wb_no, wb_f);
   assign w_wb_dec  = (w_wb_hit | w_wb_int0) & (r_out_cnt != 4'd0);

   // Clear from writeback first so that a same-register issue set wins.
   always_comb begin
      w_pend_int_nxt = r_pend_int;
      w_pend_fp_nxt  = r_pend_fp;
      if (wb_valid) begin
         if (wb_f) w_pend_fp_nxt[wb_no]  = 1'b0;
         else      w_pend_int_nxt[wb_no] = 1'b0;
      end
      if (w_issue_wr) begin
         if (in_dst_f) w_pend_fp_nxt[in_dst_no] = 1'b1;
         else          w_pend_int_nxt[in_dst_no] = 1'b1;
      end
      w_pend_int_nxt[0] = 1'b0;
   end

   always_comb begin
      w_out_cnt_nxt = r_out_cnt;
      if (w_issue_wr && !w_wb_dec)      w_out_cnt_nxt = r_out_cnt + 4'd1;
      else if (!w_issue_wr && w_wb_dec) w_out_cnt_nxt = r_out_cnt - 4'd1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (drain_req) w_state_nxt = DRAIN;
         DRAIN: begin
            if (!drain_req)                               w_state_nxt = RUN;
            else if ((r_out_cnt == 4'd0) && !wb_valid)    w_state_nxt = IDLE;
         end
         IDLE:    if (!drain_req) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= RUN;
         r_pend_int  <= '0;
         r_pend_fp   <= '0;
         r_out_cnt   <= '0;
         r_stall_cnt <= '0;
         r_wb_err    <= 1'b0;
         r_drained   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend_int <= w_pend_int_nxt;
         r_pend_fp  <= w_pend_fp_nxt;
         r_out_cnt  <= w_out_cnt_nxt;
         r_drained  <= (w_state_nxt == IDLE);
         if (stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (wb_valid && !w_wb_hit && !w_wb_int0) r_wb_err <= 1'b1;
      end
   end

   assign pend_int  = r_pend_int;
   assign pend_fp   = r_pend_fp;
   assign out_cnt   = r_out_cnt;
   assign stall_cnt = r_stall_cnt;
   assign wb_err    = r_wb_err;
   assign drained   = r_drained;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - directed self-checking bench for decode_issue_ctrl
module tb_decode_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic [4:0]  in_src1_no, in_src2_no, in_dst_no, wb_no;
   logic        in_src1_f, in_src1_use, in_src2_f, in_src2_use, in_dst_f, in_dst_wr;
   logic        flush, wb_valid, wb_f, drain_req;
   logic        issue_en, stall, drained, wb_err;
   logic [31:0] pend_int, pend_fp;
   logic [3:0]  out_cnt;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_issue_ctrl #(.MAX_OUT(8), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid),
      .in_src1_no(in_src1_no), .in_src1_f(in_src1_f), .in_src1_use(in_src1_use),
      .in_src2_no(in_src2_no), .in_src2_f(in_src2_f), .in_src2_use(in_src2_use),
      .in_dst_no(in_dst_no), .in_dst_f(in_dst_f), .in_dst_wr(in_dst_wr),
      .flush(flush), .wb_valid(wb_valid), .wb_no(wb_no), .wb_f(wb_f),
      .drain_req(drain_req), .issue_en(issue_en), .stall(stall), .drained(drained),
      .pend_int(pend_int), .pend_fp(pend_fp), .out_cnt(out_cnt),
      .stall_cnt(stall_cnt), .wb_err(wb_err)
   );

   // Register operands are encoded {float, number}.
   task automatic instr(input logic [5:0] s1, input logic u1, input logic [5:0] s2,
                        input logic u2, input logic [5:0] d, input logic w);
      in_valid = 1'b1;
      {in_src1_f, in_src1_no} = s1; in_src1_use = u1;
      {in_src2_f, in_src2_no} = s2; in_src2_use = u2;
      {in_dst_f, in_dst_no}   = d;  in_dst_wr   = w;
   endtask

   task automatic no_instr();
      in_valid = 1'b0; in_src1_use = 1'b0; in_src2_use = 1'b0; in_dst_wr = 1'b0;
      in_src1_no = '0; in_src2_no = '0; in_dst_no = '0;
      in_src1_f = 1'b0; in_src2_f = 1'b0; in_dst_f = 1'b0;
   endtask

   task automatic wb(input logic [5:0] r);
      wb_valid = 1'b1; {wb_f, wb_no} = r;
   endtask

   task automatic no_wb();
      wb_valid = 1'b0; wb_f = 1'b0; wb_no = '0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; flush = 1'b0; drain_req = 1'b0;
      no_instr(); no_wb();
      step();
      rstn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (pend_int !== 32'h0) begin failures++; $display("FAIL reset_pend_int act=%h exp=0", pend_int); end
      checks++; if (pend_fp !== 32'h0) begin failures++; $display("FAIL reset_pend_fp act=%h exp=0", pend_fp); end
      checks++; if ({out_cnt, stall_cnt, wb_err, drained} !== 22'h0) begin failures++;
         $display("FAIL reset_misc act=%h/%h/%b/%b exp=0", out_cnt, stall_cnt, wb_err, drained); end
      checks++; if ({issue_en, stall} !== 2'b00) begin failures++; $display("FAIL reset_issue act=%b%b exp=00", issue_en, stall); end
   endtask

   task automatic test_basic();
      do_reset();
      instr(6'd1, 1, 6'd2, 1, 6'd3, 1); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL basic_issue act=%b exp=1", issue_en); end
      step(); no_instr(); #1;
      checks++; if (pend_int !== 32'h8 || out_cnt !== 4'd1) begin failures++;
         $display("FAIL basic_set act=%h/%0d exp=8/1", pend_int, out_cnt); end
      instr(6'd3, 1, 6'd0, 0, 6'd4, 1); flush = 1'b1; #1;
      checks++; if ({issue_en, stall} !== 2'b00) begin failures++; $display("FAIL flush_gate act=%b%b exp=00", issue_en, stall); end
      wb(6'd3);
      step(); no_wb(); no_instr(); flush = 1'b0; #1;
      checks++; if (pend_int !== 32'h0 || out_cnt !== 4'd0 || wb_err !== 1'b0) begin failures++;
         $display("FAIL basic_wb act=%h/%0d/%b exp=0/0/0", pend_int, out_cnt, wb_err); end
   endtask

   task automatic test_raw_fp();
      do_reset();
      instr(6'd0, 0, 6'd0, 0, 6'h25, 1); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL fp_writer act=%b exp=1", issue_en); end
      step();
      for (int c = 2; c <= 5; c++) begin
         instr(6'h25, 1, 6'd1, 1, 6'd0, 0);
         if (c == 4) wb(6'h25); else no_wb();
         #1;
         checks++; if (issue_en !== (c == 5) || stall !== (c != 5)) begin failures++;
            $display("FAIL fp_dep_c%0d act=%b%b exp=%b%b", c, issue_en, stall, c == 5, c != 5); end
         step();
      end
      no_instr(); no_wb(); #1;
      checks++; if (stall_cnt !== 16'd3 || pend_fp !== 32'h0) begin failures++;
         $display("FAIL fp_stall_cnt act=%0d/%h exp=3/0", stall_cnt, pend_fp); end
   endtask

   task automatic test_full();
      do_reset();
      for (int r = 1; r <= 8; r++) begin
         instr(6'd0, 0, 6'd0, 0, 6'(r), 1); #1;
         checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL full_fill_r%0d act=%b exp=1", r, issue_en); end
         step();
      end
      checks++; if (out_cnt !== 4'd8 || pend_int !== 32'h1FE) begin failures++;
         $display("FAIL full_board act=%0d/%h exp=8/1fe", out_cnt, pend_int); end
      instr(6'd10, 1, 6'd11, 1, 6'd9, 1); #1;
      checks++; if ({issue_en, stall} !== 2'b01) begin failures++; $display("FAIL full_block act=%b%b exp=01", issue_en, stall); end
      step();
      instr(6'd10, 1, 6'd0, 0, 6'd9, 0); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL full_nowrite act=%b exp=1", issue_en); end
      step();
      instr(6'd0, 0, 6'd0, 0, 6'd9, 1); wb(6'd1); #1;
      checks++; if (issue_en !== 1'b0) begin failures++; $display("FAIL full_wb_cycle act=%b exp=0", issue_en); end
      step(); no_wb(); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL full_after_wb act=%b exp=1", issue_en); end
      step(); no_instr(); #1;
      checks++; if (out_cnt !== 4'd8 || pend_int !== 32'h3FC) begin failures++;
         $display("FAIL full_final act=%0d/%h exp=8/3fc", out_cnt, pend_int); end
   endtask

   task automatic test_r0();
      do_reset();
      instr(6'd0, 0, 6'd0, 0, 6'd0, 1); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL r0_issue act=%b exp=1", issue_en); end
      step();
      checks++; if (pend_int !== 32'h0 || out_cnt !== 4'd1) begin failures++;
         $display("FAIL r0_count act=%h/%0d exp=0/1", pend_int, out_cnt); end
      instr(6'd0, 1, 6'd0, 1, 6'd0, 1); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL r0_read act=%b exp=1", issue_en); end
      step(); no_instr(); wb(6'd0); step(); wb(6'd0); step(); no_wb(); #1;
      checks++; if (out_cnt !== 4'd0 || wb_err !== 1'b0) begin failures++;
         $display("FAIL r0_wb act=%0d/%b exp=0/0", out_cnt, wb_err); end
   endtask

   task automatic test_drain();
      do_reset();
      for (int r = 1; r <= 3; r++) begin instr(6'd0, 0, 6'd0, 0, 6'(r), 1); step(); end
      instr(6'd5, 1, 6'd0, 0, 6'd0, 0); drain_req = 1'b1; #1;
      checks++; if ({issue_en, stall} !== 2'b01) begin failures++; $display("FAIL drain_block act=%b%b exp=01", issue_en, stall); end
      step(); no_instr();
      for (int r = 1; r <= 3; r++) begin
         wb(6'(r)); #1;
         checks++; if (drained !== 1'b0) begin failures++; $display("FAIL drain_early_r%0d act=%b exp=0", r, drained); end
         step();
      end
      no_wb(); #1;
      checks++; if (out_cnt !== 4'd0 || drained !== 1'b0) begin failures++;
         $display("FAIL drain_cnt0 act=%0d/%b exp=0/0", out_cnt, drained); end
      step();
      checks++; if (drained !== 1'b1) begin failures++; $display("FAIL drain_done act=%b exp=1", drained); end
      drain_req = 1'b0; instr(6'd1, 1, 6'd0, 0, 6'd4, 1); step();
      checks++; if (drained !== 1'b0 || issue_en !== 1'b1) begin failures++;
         $display("FAIL drain_resume act=%b/%b exp=0/1", drained, issue_en); end
      step(); no_instr();
   endtask

   task automatic test_wb_err_reset();
      do_reset();
      wb(6'd7); step(); no_wb(); step(); step();
      checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL wb_err_sticky act=%b exp=1", wb_err); end
      instr(6'd0, 0, 6'd0, 0, 6'd4, 1); step();
      instr(6'd0, 0, 6'd0, 0, 6'h25, 1); step();
      no_instr(); drain_req = 1'b1; step();
      rstn = 1'b0; #1;
      checks++; if ({pend_int, pend_fp, out_cnt, stall_cnt, wb_err, drained} !== 86'h0) begin failures++;
         $display("FAIL async_reset act=%h/%h/%0d/%0d/%b/%b exp=0", pend_int, pend_fp, out_cnt, stall_cnt, wb_err, drained); end
      drain_req = 1'b0; step(); rstn = 1'b1;
      instr(6'd4, 1, 6'h25, 1, 6'd4, 1); #1;
      checks++; if (issue_en !== 1'b1) begin failures++; $display("FAIL reset_state_run act=%b exp=1", issue_en); end
      step(); no_instr();
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; drain_req = 1'b0;
      no_instr(); no_wb();
      test_reset();
      test_basic();
      test_raw_fp();
      test_full();
      test_r0();
      test_drain();
      test_wb_err_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
